// File: rtl/l2mt_tbl_init.sv
// L2 MAC table / age table init engine.
// Sweeps both RAMs with init values, then passes user writes through.

module l2mt_tbl_init_fsm #(
  parameter int            AW       = 12,
  parameter int            DEPTH    = 4096,
  parameter int            DW       = 72,
  parameter logic [DW-1:0] INIT_VAL = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          init_req,
  input  logic          usr_en,
  input  logic [AW-1:0] usr_addr,
  input  logic [DW-1:0] usr_data,
  output logic          rdy,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic          finish
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CLR  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [1:0]    state;
  logic [AW-1:0] cnt;
  logic          clr_en;
  logic [DW-1:0] clr_data;
  logic          fin;

  // Sweep sequencer: cnt is the address currently presented.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      clr_en   <= 1'b0;
      clr_data <= '0;
      fin      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          state    <= CLR;
          cnt      <= '0;
          clr_en   <= 1'b1;
          clr_data <= INIT_VAL;
          fin      <= 1'b0;
        end
        CLR: begin
          if (init_req) begin
            cnt <= '0;
          end else if (cnt == LAST) begin
            state    <= DONE;
            cnt      <= '0;
            clr_en   <= 1'b0;
            clr_data <= '0;
            fin      <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (init_req) begin
            state    <= CLR;
            cnt      <= '0;
            clr_en   <= 1'b1;
            clr_data <= INIT_VAL;
            fin      <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          cnt      <= '0;
          clr_en   <= 1'b0;
          clr_data <= '0;
          fin      <= 1'b0;
        end
      endcase
    end
  end

  // Clean table: RAM port follows the user port with no latency.
  always_comb begin
    rdy     = fin;
    finish  = fin;
    wr_en   = clr_en;
    wr_addr = cnt;
    wr_data = clr_data;
    if (fin) begin
      wr_en   = usr_en;
      wr_addr = usr_addr;
      wr_data = usr_data;
    end
  end

endmodule

module l2mt_tbl_init #(
  parameter int                 MACT_AW       = 12,
  parameter int                 MACT_DEPTH    = 4096,
  parameter int                 MACT_DW       = 72,
  parameter logic [MACT_DW-1:0] MACT_INIT_VAL = '0,
  parameter int                 AGE_AW        = 12,
  parameter int                 AGE_DEPTH     = 4096,
  parameter int                 AGE_DW        = 8,
  parameter logic [AGE_DW-1:0]  AGE_INIT_VAL  = '0
) (
  input  logic               syc_clk_250m,
  input  logic               sys_reset_n,
  input  logic               init_req,
  input  logic               usr_mact_wr_en,
  input  logic [MACT_AW-1:0] usr_mact_wr_addr,
  input  logic [MACT_DW-1:0] usr_mact_wr_data,
  output logic               usr_mact_wr_rdy,
  input  logic               usr_age_wr_en,
  input  logic [AGE_AW-1:0]  usr_age_wr_addr,
  input  logic [AGE_DW-1:0]  usr_age_wr_data,
  output logic               usr_age_wr_rdy,
  output logic               mact_wr_en,
  output logic [MACT_AW-1:0] mact_wr_addr,
  output logic [MACT_DW-1:0] mact_wr_data,
  output logic               age_wr_en,
  output logic [AGE_AW-1:0]  age_wr_addr,
  output logic [AGE_DW-1:0]  age_wr_data,
  output logic               l2mt_mact_ini_finish,
  output logic               l2mt_age_r_ini_finish,
  output logic               init_busy
);

  l2mt_tbl_init_fsm #(
    .AW       (MACT_AW),
    .DEPTH    (MACT_DEPTH),
    .DW       (MACT_DW),
    .INIT_VAL (MACT_INIT_VAL)
  ) u_mact (
    .clk      (syc_clk_250m),
    .rst_n    (sys_reset_n),
    .init_req (init_req),
    .usr_en   (usr_mact_wr_en),
    .usr_addr (usr_mact_wr_addr),
    .usr_data (usr_mact_wr_data),
    .rdy      (usr_mact_wr_rdy),
    .wr_en    (mact_wr_en),
    .wr_addr  (mact_wr_addr),
    .wr_data  (mact_wr_data),
    .finish   (l2mt_mact_ini_finish)
  );

  l2mt_tbl_init_fsm #(
    .AW       (AGE_AW),
    .DEPTH    (AGE_DEPTH),
    .DW       (AGE_DW),
    .INIT_VAL (AGE_INIT_VAL)
  ) u_age (
    .clk      (syc_clk_250m),
    .rst_n    (sys_reset_n),
    .init_req (init_req),
    .usr_en   (usr_age_wr_en),
    .usr_addr (usr_age_wr_addr),
    .usr_data (usr_age_wr_data),
    .rdy      (usr_age_wr_rdy),
    .wr_en    (age_wr_en),
    .wr_addr  (age_wr_addr),
    .wr_data  (age_wr_data),
    .finish   (l2mt_age_r_ini_finish)
  );

  assign init_busy = !(l2mt_mact_ini_finish && l2mt_age_r_ini_finish);

endmodule

// File: tb/tb_l2mt_tbl_init.sv
// Bench for l2mt_tbl_init: random user writes and re-init
// requests against a sweep-position model and RAM shadow.

module tb_l2mt_tbl_init;

  localparam int MAW = 12;
  localparam int MD  = 16;
  localparam int MDW = 72;
  localparam int AAW = 12;
  localparam int AD  = 8;
  localparam int ADW = 8;
  localparam logic [MDW-1:0] MINIT = '0;
  localparam logic [ADW-1:0] AINIT = 8'hFF;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           init_req;
  logic           usr_mact_wr_en;
  logic [MAW-1:0] usr_mact_wr_addr;
  logic [MDW-1:0] usr_mact_wr_data;
  logic           usr_mact_wr_rdy;
  logic           usr_age_wr_en;
  logic [AAW-1:0] usr_age_wr_addr;
  logic [ADW-1:0] usr_age_wr_data;
  logic           usr_age_wr_rdy;
  logic           mact_wr_en;
  logic [MAW-1:0] mact_wr_addr;
  logic [MDW-1:0] mact_wr_data;
  logic           age_wr_en;
  logic [AAW-1:0] age_wr_addr;
  logic [ADW-1:0] age_wr_data;
  logic           mact_fin;
  logic           age_fin;
  logic           init_busy;

  l2mt_tbl_init #(
    .MACT_AW       (MAW),
    .MACT_DEPTH    (MD),
    .MACT_DW       (MDW),
    .MACT_INIT_VAL (MINIT),
    .AGE_AW        (AAW),
    .AGE_DEPTH     (AD),
    .AGE_DW        (ADW),
    .AGE_INIT_VAL  (AINIT)
  ) dut (
    .syc_clk_250m          (clk),
    .sys_reset_n           (rst_n),
    .init_req              (init_req),
    .usr_mact_wr_en        (usr_mact_wr_en),
    .usr_mact_wr_addr      (usr_mact_wr_addr),
    .usr_mact_wr_data      (usr_mact_wr_data),
    .usr_mact_wr_rdy       (usr_mact_wr_rdy),
    .usr_age_wr_en         (usr_age_wr_en),
    .usr_age_wr_addr       (usr_age_wr_addr),
    .usr_age_wr_data       (usr_age_wr_data),
    .usr_age_wr_rdy        (usr_age_wr_rdy),
    .mact_wr_en            (mact_wr_en),
    .mact_wr_addr          (mact_wr_addr),
    .mact_wr_data          (mact_wr_data),
    .age_wr_en             (age_wr_en),
    .age_wr_addr           (age_wr_addr),
    .age_wr_data           (age_wr_data),
    .l2mt_mact_ini_finish  (mact_fin),
    .l2mt_age_r_ini_finish (age_fin),
    .init_busy             (init_busy)
  );

  always #5 clk = ~clk;

  logic [MDW-1:0] dut_mram [MD];
  logic [ADW-1:0] dut_aram [AD];
  logic [MDW-1:0] exp_mram [MD];
  logic [ADW-1:0] exp_aram [AD];

  always @(posedge clk) begin
    if (mact_wr_en) dut_mram[mact_wr_addr[3:0]] <= mact_wr_data;
    if (age_wr_en)  dut_aram[age_wr_addr[2:0]]  <= age_wr_data;
  end

  int checks = 0;
  int errors = 0;

  // mp/ap: edges since the current sweep began; > DEPTH means clean
  int mp, ap;
  int edge_no;
  int m_rise, m_fall, a_rise, b_fall;
  logic m_prev, a_prev, b_prev;
  logic m_acc, a_acc, rand_en;

  logic           e_men, e_aen;
  logic [MAW-1:0] e_maddr;
  logic [AAW-1:0] e_aaddr;
  logic [MDW-1:0] e_mdata;
  logic [ADW-1:0] e_adata;

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_out();
    if (mp > MD) begin
      e_men = usr_mact_wr_en;
      e_maddr = usr_mact_wr_addr;
      e_mdata = usr_mact_wr_data;
    end else if (mp >= 1) begin
      e_men = 1'b1;
      e_maddr = MAW'(mp - 1);
      e_mdata = MINIT;
    end else begin
      e_men = 1'b0;
      e_maddr = '0;
      e_mdata = '0;
    end
    if (ap > AD) begin
      e_aen = usr_age_wr_en;
      e_aaddr = usr_age_wr_addr;
      e_adata = usr_age_wr_data;
    end else if (ap >= 1) begin
      e_aen = 1'b1;
      e_aaddr = AAW'(ap - 1);
      e_adata = AINIT;
    end else begin
      e_aen = 1'b0;
      e_aaddr = '0;
      e_adata = '0;
    end
  endtask

  task automatic compare();
    model_out();
    check("m_en", 128'(mact_wr_en), 128'(e_men));
    check("m_addr", 128'(mact_wr_addr), 128'(e_maddr));
    check("m_data", 128'(mact_wr_data), 128'(e_mdata));
    check("m_fin", 128'(mact_fin), 128'(mp > MD));
    check("m_rdy", 128'(usr_mact_wr_rdy), 128'(mp > MD));
    check("a_en", 128'(age_wr_en), 128'(e_aen));
    check("a_addr", 128'(age_wr_addr), 128'(e_aaddr));
    check("a_data", 128'(age_wr_data), 128'(e_adata));
    check("a_fin", 128'(age_fin), 128'(ap > AD));
    check("a_rdy", 128'(usr_age_wr_rdy), 128'(ap > AD));
    check("busy", 128'(init_busy), 128'(!((mp > MD) && (ap > AD))));
  endtask

  task automatic drive_usr();
    logic [95:0] r;
    if (m_acc) usr_mact_wr_en = 1'b0;
    if (a_acc) usr_age_wr_en = 1'b0;
    if (rand_en && !usr_mact_wr_en && $urandom_range(0, 3) == 0) begin
      r = {$urandom(), $urandom(), $urandom()};
      usr_mact_wr_en = 1'b1;
      usr_mact_wr_addr = MAW'($urandom_range(0, MD - 1));
      usr_mact_wr_data = r[MDW-1:0];
    end
    if (rand_en && !usr_age_wr_en && $urandom_range(0, 3) == 0) begin
      usr_age_wr_en = 1'b1;
      usr_age_wr_addr = AAW'($urandom_range(0, AD - 1));
      usr_age_wr_data = ADW'($urandom_range(0, 255));
    end
  endtask

  task automatic track();
    if (mact_fin !== m_prev) begin
      if (mact_fin) m_rise = edge_no;
      else m_fall = edge_no;
    end
    if (age_fin !== a_prev && age_fin) a_rise = edge_no;
    if (init_busy !== b_prev && !init_busy) b_fall = edge_no;
    m_prev = mact_fin;
    a_prev = age_fin;
    b_prev = init_busy;
  endtask

  task automatic step();
    model_out();
    m_acc = 1'b0;
    a_acc = 1'b0;
    if (rst_n) begin
      if (e_men) exp_mram[e_maddr[3:0]] = e_mdata;
      if (e_aen) exp_aram[e_aaddr[2:0]] = e_adata;
      m_acc = usr_mact_wr_en && (mp > MD);
      a_acc = usr_age_wr_en && (ap > AD);
      if (init_req) begin
        mp = 1;
        ap = 1;
      end else begin
        if (mp <= MD) mp++;
        if (ap <= AD) ap++;
      end
    end
    @(posedge clk);
    if (rst_n) edge_no++;
    #1;
    compare();
    track();
    drive_usr();
  endtask

  task automatic clr_marks();
    m_rise = -1;
    m_fall = -1;
    a_rise = -1;
    b_fall = -1;
  endtask

  int m;
  logic [MDW-1:0] d3;

  initial begin
    rst_n = 1'b1;
    init_req = 1'b0;
    usr_mact_wr_en = 1'b0;
    usr_mact_wr_addr = '0;
    usr_mact_wr_data = '0;
    usr_age_wr_en = 1'b0;
    usr_age_wr_addr = '0;
    usr_age_wr_data = '0;
    rand_en = 1'b0;
    mp = 0;
    ap = 0;
    edge_no = 0;
    m_prev = 1'b0;
    a_prev = 1'b0;
    b_prev = 1'b1;
    clr_marks();
    #1 rst_n = 1'b0;
    #1;
    compare();
    check("rst_busy", 128'(init_busy), 128'(1));
    check("rst_mfin", 128'(mact_fin), 128'(0));
    for (int i = 0; i < 3; i++) step();

    // initial sweep with user writes pending during CLR
    @(negedge clk);
    rst_n = 1'b1;
    edge_no = 0;
    clr_marks();
    rand_en = 1'b1;
    for (int i = 0; i < 20; i++) step();
    check("m_rise_init", 128'(m_rise), 128'(17));
    check("a_rise_init", 128'(a_rise), 128'(9));
    check("busy_fall", 128'(b_fall), 128'(17));

    // pass-through of a single directed write
    rand_en = 1'b0;
    step();
    step();
    usr_mact_wr_en = 1'b1;
    usr_mact_wr_addr = 12'd5;
    usr_mact_wr_data = 72'hABC;
    #1;
    check("pass_en", 128'(mact_wr_en), 128'(1));
    check("pass_addr", 128'(mact_wr_addr), 128'(5));
    check("pass_data", 128'(mact_wr_data), 128'(72'hABC));
    check("pass_rdy", 128'(usr_mact_wr_rdy), 128'(1));
    step();
    check("pass_ram", 128'(dut_mram[5]), 128'(72'hABC));

    // re-init from DONE with a simultaneous write
    for (int i = 0; i < 20 && edge_no < 30; i++) step();
    init_req = 1'b1;
    d3 = 72'h1234_5678_9ABC_DEF0_11;
    usr_mact_wr_en = 1'b1;
    usr_mact_wr_addr = 12'd3;
    usr_mact_wr_data = d3;
    clr_marks();
    #1;
    check("req_pass_addr", 128'(mact_wr_addr), 128'(3));
    step();
    init_req = 1'b0;
    check("req_wr_ram", 128'(dut_mram[3]), 128'(d3));
    rand_en = 1'b1;
    for (int i = 0; i < 20 && edge_no < 50; i++) step();
    check("req_m_fall", 128'(m_fall), 128'(31));
    check("req_m_rise", 128'(m_rise), 128'(47));

    // re-init mid-sweep at address 9
    init_req = 1'b1;
    step();
    init_req = 1'b0;
    for (int i = 0; i < 40 && mp != 10; i++) step();
    check("mid_at9", 128'(mact_wr_addr), 128'(9));
    m = edge_no;
    init_req = 1'b1;
    step();
    init_req = 1'b0;
    check("mid_addr0", 128'(mact_wr_addr), 128'(0));
    clr_marks();
    for (int i = 0; i < 20; i++) step();
    check("mid_rise", 128'(m_rise - m), 128'(17));

    // reset asserted mid-sweep at address 6
    init_req = 1'b1;
    step();
    init_req = 1'b0;
    for (int i = 0; i < 40 && mp != 7; i++) step();
    check("rs_at6", 128'(mact_wr_addr), 128'(6));
    rst_n = 1'b0;
    #1;
    mp = 0;
    ap = 0;
    compare();
    check("rs_m_en", 128'(mact_wr_en), 128'(0));
    check("rs_m_addr", 128'(mact_wr_addr), 128'(0));
    check("rs_a_en", 128'(age_wr_en), 128'(0));
    check("rs_busy", 128'(init_busy), 128'(1));
    track();
    step();
    step();
    @(negedge clk);
    rst_n = 1'b1;
    edge_no = 0;
    clr_marks();
    step();
    check("rs_first_addr", 128'(mact_wr_addr), 128'(0));
    for (int i = 0; i < 19; i++) step();
    check("rs_m_rise", 128'(m_rise), 128'(17));
    check("rs_a_rise", 128'(a_rise), 128'(9));

    // random traffic and random re-init requests
    for (int i = 0; i < 400; i++) begin
      init_req = ($urandom_range(0, 39) == 0);
      step();
    end
    init_req = 1'b0;
    rand_en = 1'b0;
    for (int i = 0; i < 20; i++) step();

    for (int i = 0; i < MD; i++)
      check("mram", 128'(dut_mram[i]), 128'(exp_mram[i]));
    for (int i = 0; i < AD; i++)
      check("aram", 128'(dut_aram[i]), 128'(exp_aram[i]));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
